// File: rtl/display_pkg.sv
// Shared constants and types for the display path: BCD converter, display controller and
// segment decoder all agree on digit width, blank code and saturation digit.
package display_pkg;

  localparam int unsigned DIGIT_W            = 4;
  localparam int unsigned NUM_DISPLAY_DIGITS = 8;

  localparam logic [3:0] BLANK_CODE    = 4'hF;
  localparam logic [3:0] BCD_SAT_DIGIT = 4'h9;
  localparam logic [3:0] DIGIT_ZERO    = 4'h0;
  localparam logic [3:0] DIGIT_MAX     = 4'h9;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } bcd_state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: any digit of 5 or more gets +3 before the next shift.
module bcd_digit_adjust (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-packed-BCD converter, one double-dabble bit per clock, with saturation.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code.
module bin_to_bcd_serial
  import display_pkg::*;
#(
  parameter int unsigned BIN_WIDTH  = 27,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [BIN_WIDTH-1:0]    bin_in_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_value_o,
  output logic                    overflow_o
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  bcd_state_e           state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BcdW-1:0]      work_q, work_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [BcdW-1:0]      adj;
  logic [BcdW-1:0]      work_shift;
  logic [BIN_WIDTH-1:0] bin_shift;
  logic                 flag_next;
  logic [BcdW-1:0]      result;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // Bit leaving the top digit means the running value crossed 10^NUM_DIGITS.
  assign work_shift = {adj[BcdW-2:0], bin_q[BIN_WIDTH-1]};
  assign bin_shift  = {bin_q[BIN_WIDTH-2:0], 1'b0};
  assign flag_next  = ovf_flag_q | adj[BcdW-1];

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nonzero;

  always_comb begin
    result       = work_shift;
    seen_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (work_shift[4*i +: 4] != DIGIT_ZERO) begin
        seen_nonzero = 1'b1;
      end else if (!seen_nonzero) begin
        result[4*i +: 4] = BLANK_CODE;
      end
    end
  end
`else
  assign result = work_shift;
`endif

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    work_d     = work_q;
    ovf_flag_d = ovf_flag_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d      = bin_in_i;
          work_d     = '0;
          ovf_flag_d = 1'b0;
          cnt_d      = CntW'(BIN_WIDTH);
          state_d    = StShift;
        end
      end
      StShift: begin
        bin_d      = bin_shift;
        work_d     = work_shift;
        ovf_flag_d = flag_next;
        cnt_d      = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          bcd_d   = flag_next ? {NUM_DIGITS{BCD_SAT_DIGIT}} : result;
          ovf_d   = flag_next;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      work_q     <= '0;
      ovf_flag_q <= 1'b0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      work_q     <= work_d;
      ovf_flag_q <= ovf_flag_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy_o      = (state_q == StShift);
  assign done_o      = done_q;
  assign bcd_value_o = bcd_q;
  assign overflow_o  = ovf_q;

endmodule
